// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA framebuffer geometry constants and write-side FSM state type
package vga_pkg;
    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int FB_WORDS = H_RES * V_RES;
    localparam int ADDR_W   = 19;
    localparam int PIX_W    = 8;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        FILL = 2'd2
    } wr_state_e;
endpackage

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - synchronous write-request queue of {x, y, pixel} entries
module vram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/vram_writer.sv
// rtl/vram_writer.sv - framebuffer port-A write front end: (x,y) pixel writes and full-screen fills
module vram_writer #(
    parameter int H_RES      = vga_pkg::H_RES,
    parameter int V_RES      = vga_pkg::V_RES,
    parameter int ADDR_W     = vga_pkg::ADDR_W,
    parameter int PIX_W      = vga_pkg::PIX_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [9:0]        wr_x,
    input  logic [9:0]        wr_y,
    input  logic [PIX_W-1:0]  wr_pixel,
    input  logic              fill_start,
    input  logic [PIX_W-1:0]  fill_color,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              fill_done,
    output logic [7:0]        oob_count
);
    localparam int COORD_W = vga_pkg::COORD_W;
    localparam int ENTRY_W = 2 * COORD_W + PIX_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0]  FILL_LAST = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [COORD_W-1:0] X_LIM     = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] Y_LIM     = COORD_W'(V_RES);

    vga_pkg::wr_state_e state_q, state_d;

    logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count, next_count;
    logic               in_range, accept, push, pop, fill_last;
    logic [COORD_W-1:0] head_x, head_y;
    logic [PIX_W-1:0]   head_pix;
    logic [ADDR_W-1:0]  head_addr;

    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [PIX_W-1:0]   ram_data_q, ram_data_d;
    logic               ram_wren_q, ram_wren_d;
    logic [ADDR_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic [PIX_W-1:0]   color_q, color_d;
    logic               fill_end_q, fill_end_d;
    logic               fill_done_q, fill_done_d;
    logic               busy_q, busy_d;
    logic [7:0]         oob_q, oob_d;

    assign in_range   = (wr_x < X_LIM) && (wr_y < Y_LIM);
    assign wr_ready   = !rst && !fifo_full && (state_q != vga_pkg::PEND);
    assign accept     = wr_valid && wr_ready;
    assign push       = accept && in_range;
    // Queued writes are frozen during FILL so they land over the fill afterwards.
    assign pop        = !fifo_empty && (state_q != vga_pkg::FILL);
    assign next_count = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign fill_last  = (state_q == vga_pkg::FILL) && (fill_cnt_q == FILL_LAST);
    assign fifo_wdata = {wr_x, wr_y, wr_pixel};
    assign {head_x, head_y, head_pix} = fifo_rdata;

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_wdata),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // 640 = 512 + 128, so the row offset is two shifts and an add.
    always_comb begin
        head_addr = '0;
        if (H_RES == 640) begin
            head_addr = (ADDR_W'(head_y) << 9) + (ADDR_W'(head_y) << 7) + ADDR_W'(head_x);
        end else begin
            head_addr = ADDR_W'(head_y) * ADDR_W'(H_RES) + ADDR_W'(head_x);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= vga_pkg::IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A fill only starts once every write accepted before it has popped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            vga_pkg::IDLE: begin
                if (fill_start) begin
                    state_d = (next_count == '0) ? vga_pkg::FILL : vga_pkg::PEND;
                end
            end
            vga_pkg::PEND: begin
                if (next_count == '0) begin
                    state_d = vga_pkg::FILL;
                end
            end
            vga_pkg::FILL: begin
                if (fill_last) begin
                    state_d = vga_pkg::IDLE;
                end
            end
            default: state_d = vga_pkg::IDLE;
        endcase
    end

    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wren_d = 1'b0;
        fill_cnt_d = fill_cnt_q;
        color_d    = color_q;
        if ((state_q == vga_pkg::IDLE) && fill_start) begin
            color_d = fill_color;
        end
        if (pop) begin
            ram_addr_d = head_addr;
            ram_data_d = head_pix;
            ram_wren_d = 1'b1;
        end else if (state_q == vga_pkg::FILL) begin
            ram_addr_d = fill_cnt_q;
            ram_data_d = color_q;
            ram_wren_d = 1'b1;
            fill_cnt_d = fill_last ? '0 : fill_cnt_q + ADDR_W'(1);
        end
        fill_end_d  = fill_last;
        fill_done_d = fill_end_q;
        oob_d       = oob_q;
        if (accept && !in_range && (oob_q != 8'hFF)) begin
            oob_d = oob_q + 8'd1;
        end
        busy_d = (next_count != '0) || (state_d != vga_pkg::IDLE) || ram_wren_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_wren_q  <= 1'b0;
            fill_cnt_q  <= '0;
            color_q     <= '0;
            fill_end_q  <= 1'b0;
            fill_done_q <= 1'b0;
            busy_q      <= 1'b0;
            oob_q       <= '0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_wren_q  <= ram_wren_d;
            fill_cnt_q  <= fill_cnt_d;
            color_q     <= color_d;
            fill_end_q  <= fill_end_d;
            fill_done_q <= fill_done_d;
            busy_q      <= busy_d;
            oob_q       <= oob_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign ram_wren  = ram_wren_q;
    assign busy      = busy_q;
    assign fill_done = fill_done_q;
    assign oob_count = oob_q;
endmodule
